// File: rtl/sm_pulse_driver.sv
// sm_pulse_driver
//
// Stimulus and transmit end for the 4-phase x/y pulse-counting FSM.
// On a start command it sends a train of single-cycle x pulses, separated by
// a programmable number of idle cycles. It also runs a bit-exact model of the
// downstream counter FSM and flags any returned y that differs from the
// model's prediction.
//
// Optional feature (define the macro to enable):
//   SM_DRV_ERRCNT_EN - adds err_cnt[7:0], a saturating count of mismatching edges.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high; clears all state and outputs
//   start      in   command strobe, only looked at in IDLE
//   count      in   number of x pulses to send (0 = complete with no pulse)
//   gap        in   number of x=0 cycles between consecutive pulses
//   phase_clr  in   synchronous clear of the downstream model
//   y_in       in   y returned by the downstream FSM
//   x          out  registered pulse output to the downstream FSM
//   busy       out  high from an accepted start until done
//   done       out  one-cycle completion pulse
//   exp_phase  out  model's predicted downstream state (0..3)
//   err        out  sticky mismatch flag, cleared by an accepted start
//   err_cnt    out  (SM_DRV_ERRCNT_EN only) saturating mismatch count
//
// Handshake: start is a level sampled on each rising edge while IDLE; it is
// accepted on that edge and ignored (never queued) while a command is running.
// busy rises the cycle after acceptance and done pulses for exactly one cycle
// at the end, with busy already low.

module sm_pulse_driver #(
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [GAP_W-1:0] gap,
    input  logic             phase_clr,
    input  logic             y_in,
    output logic             x,
    output logic             busy,
    output logic             done,
    output logic [1:0]       exp_phase,
`ifdef SM_DRV_ERRCNT_EN
    output logic [7:0]       err_cnt,
`endif
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PULSE  = 3'd1,
        GAP    = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [GAP_W-1:0] GAP_ONE = 1;

    state_t           state, state_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic [GAP_W-1:0] gap_r, gap_r_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic [1:0]       settle_cnt, settle_cnt_n;
    logic             accept;
    logic             exp_y;
    logic             mismatch;

    // Next-state and counter logic.
    always_comb begin
        state_n      = state;
        rem_n        = rem;
        gap_r_n      = gap_r;
        gap_cnt_n    = gap_cnt;
        settle_cnt_n = settle_cnt;
        accept       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (count != '0) begin
                        rem_n   = count;
                        gap_r_n = gap;
                        state_n = PULSE;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            PULSE: begin
                rem_n = rem - CNT_ONE;
                if (rem == CNT_ONE) begin
                    // Two quiet cycles so the response to the last pulse
                    // has come back on y_in before we report done.
                    settle_cnt_n = 2'd2;
                    state_n      = SETTLE;
                end else if (gap_r != '0) begin
                    gap_cnt_n = gap_r;
                    state_n   = GAP;
                end
                // gap_r == 0: stay in PULSE, x stays high back-to-back.
            end
            GAP: begin
                gap_cnt_n = gap_cnt - GAP_ONE;
                // Leaving on the edge where the counter expires gives exactly
                // gap_r cycles with x low.
                if (gap_cnt == GAP_ONE) begin
                    state_n = PULSE;
                end
            end
            SETTLE: begin
                settle_cnt_n = settle_cnt - 2'd1;
                if (settle_cnt == 2'd1) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Checking only runs while a command is in flight.
    assign mismatch = (state != IDLE) && (y_in != exp_y);

    // FSM state, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rem        <= '0;
            gap_r      <= '0;
            gap_cnt    <= '0;
            settle_cnt <= 2'd0;
            x          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            rem        <= rem_n;
            gap_r      <= gap_r_n;
            gap_cnt    <= gap_cnt_n;
            settle_cnt <= settle_cnt_n;
            x          <= (state_n == PULSE);
            busy       <= (state_n == PULSE) || (state_n == GAP) || (state_n == SETTLE);
            done       <= (state_n == DONE);
        end
    end

    // Model of the downstream FSM. It advances from the x value currently on
    // the wire; the x=0 step from phase 3 back to 1 is a property of the
    // downstream design. exp_y lags phase by one edge like its registered y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_phase <= 2'd0;
            exp_y     <= 1'b0;
        end else if (phase_clr) begin
            exp_phase <= 2'd0;
            exp_y     <= 1'b0;
        end else begin
            exp_y <= exp_phase[0];
            if (x) begin
                exp_phase <= exp_phase + 2'd1;
            end else if (exp_phase == 2'd3) begin
                exp_phase <= 2'd1;
            end
        end
    end

    // Sticky error flag. accept only happens in IDLE and mismatch only outside
    // IDLE, so the two never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if (mismatch) begin
            err <= 1'b1;
        end
    end

`ifdef SM_DRV_ERRCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= 8'd0;
        end else if (accept) begin
            err_cnt <= 8'd0;
        end else if (mismatch && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
